// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memCtrl port between the CPU (read/write) and the VIC-II (read-only).
// Define MEM_ARB_TIMEOUT_EN to abort any memCtrl phase lasting TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter bit VIC_PRIORITY   = 1'b0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [6:0]  cpu_bank,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        vic_req,
  input  logic [6:0]  vic_bank,
  input  logic [15:0] vic_addr,
  output logic        vic_ack,
  output logic [7:0]  vic_rdata,
  output logic        err,
  output logic        arb_busy,
  output logic        mem_ce,
  output logic        mem_write,
  output logic [6:0]  mem_bank,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_busy
);
  typedef enum logic [1:0] {IDLE, ACCEPT, DONE} state_t;
  state_t      state_q, state_d;
  logic        gnt_vic_q, gnt_vic_d, last_vic_q, last_vic_d;
  logic        mem_ce_q, mem_ce_d, mem_write_q, mem_write_d;
  logic [6:0]  mem_bank_q, mem_bank_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        cpu_ack_q, cpu_ack_d, vic_ack_q, vic_ack_d, err_q, err_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d, vic_rdata_q, vic_rdata_d;
  logic        grant, pick_vic, timeout, finish;
  logic [7:0]  ret_data;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        progress;
  assign progress = (state_q == ACCEPT && mem_busy) || (state_q == DONE && !mem_busy);
  assign timeout  = state_q != IDLE && !progress && cnt_q == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif
  // The ack cycle is blocked so a requester still holding req is not re-granted.
  assign grant    = state_q == IDLE && !mem_busy && !cpu_ack_q && !vic_ack_q && (cpu_req || vic_req);
  assign pick_vic = vic_req && (!cpu_req || VIC_PRIORITY || !last_vic_q);
  assign finish   = (state_q == DONE && !mem_busy) || timeout;
  assign ret_data = timeout ? 8'hFF : mem_rdata;
  always_comb begin
    state_d     = state_q;
    gnt_vic_d   = gnt_vic_q;
    last_vic_d  = last_vic_q;
    mem_ce_d    = mem_ce_q;
    mem_write_d = mem_write_q;
    mem_bank_d  = mem_bank_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vic_rdata_d = vic_rdata_q;
    cpu_ack_d   = 1'b0;
    vic_ack_d   = 1'b0;
    err_d       = 1'b0;
    if (grant) begin
      state_d     = ACCEPT;
      gnt_vic_d   = pick_vic;
      last_vic_d  = pick_vic;
      mem_ce_d    = 1'b1;
      mem_write_d = pick_vic ? 1'b0 : cpu_we;
      mem_bank_d  = pick_vic ? vic_bank : cpu_bank;
      mem_addr_d  = pick_vic ? vic_addr : cpu_addr;
      mem_wdata_d = pick_vic ? 8'h00 : cpu_wdata;
    end
    if (state_q == ACCEPT && mem_busy) begin
      state_d  = DONE;
      mem_ce_d = 1'b0;
    end
    if (finish) begin
      state_d     = IDLE;
      mem_ce_d    = 1'b0;
      cpu_ack_d   = !gnt_vic_q;
      vic_ack_d   = gnt_vic_q;
      err_d       = timeout;
      cpu_rdata_d = gnt_vic_q ? cpu_rdata_q : ret_data;
      vic_rdata_d = gnt_vic_q ? ret_data : vic_rdata_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_vic_q   <= 1'b0;
      last_vic_q  <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_write_q <= 1'b0;
      mem_bank_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      vic_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vic_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_vic_q   <= gnt_vic_d;
      last_vic_q  <= last_vic_d;
      mem_ce_q    <= mem_ce_d;
      mem_write_q <= mem_write_d;
      mem_bank_q  <= mem_bank_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vic_rdata_q <= vic_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vic_ack_q   <= vic_ack_d;
      err_q       <= err_d;
    end
  end
  assign arb_busy  = state_q != IDLE;
  assign mem_ce    = mem_ce_q;
  assign mem_write = mem_write_q;
  assign mem_bank  = mem_bank_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign vic_ack   = vic_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vic_rdata = vic_rdata_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a small memCtrl busy model.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vic_req = 1'b0;
  logic [6:0]  cpu_bank = '0, vic_bank = '0;
  logic [15:0] cpu_addr = '0, vic_addr = '0;
  logic [7:0]  cpu_wdata = '0, rd_val = '0;
  logic        force_busy = 1'b1, hold_model = 1'b0, mdl_busy;
  logic [1:0]  mdl_cnt;
  logic        mem_busy;
  logic [7:0]  mem_rdata;
  logic        cpu_ack, vic_ack, err, arb_busy, mem_ce, mem_write;
  logic [7:0]  cpu_rdata, vic_rdata, mem_wdata;
  logic [6:0]  mem_bank;
  logic [15:0] mem_addr;
  logic        p_cpu_ack, p_vic_ack, p_err, p_arb_busy, p_mem_ce, p_mem_write;
  logic [7:0]  p_cpu_rdata, p_vic_rdata, p_mem_wdata;
  logic [6:0]  p_mem_bank;
  logic [15:0] p_mem_addr;
  logic [52:0] outs;
  int          n_chk = 0, n_fail = 0, both_ack = 0;
  assign mem_busy  = force_busy | mdl_busy;
  assign mem_rdata = rd_val;
  assign outs = {cpu_ack, cpu_rdata, vic_ack, vic_rdata, err, arb_busy, mem_ce, mem_write,
                 mem_bank, mem_addr, mem_wdata};
  mem_arbiter #(.VIC_PRIORITY(1'b0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vic_req(vic_req), .vic_bank(vic_bank), .vic_addr(vic_addr), .vic_ack(vic_ack),
    .vic_rdata(vic_rdata), .err(err), .arb_busy(arb_busy),
    .mem_ce(mem_ce), .mem_write(mem_write), .mem_bank(mem_bank), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy));
  mem_arbiter #(.VIC_PRIORITY(1'b1), .TIMEOUT_CYCLES(16)) dut_prio (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata),
    .vic_req(vic_req), .vic_bank(vic_bank), .vic_addr(vic_addr), .vic_ack(p_vic_ack),
    .vic_rdata(p_vic_rdata), .err(p_err), .arb_busy(p_arb_busy),
    .mem_ce(p_mem_ce), .mem_write(p_mem_write), .mem_bank(p_mem_bank), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy));
  always #5 clk = ~clk;
  // memCtrl stand-in: busy rises the cycle after CE is seen and stays high for three cycles
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= '0;
    end else if (mdl_cnt != 2'd0) begin
      mdl_cnt  <= mdl_cnt - 2'd1;
      mdl_busy <= mdl_cnt != 2'd1;
    end else if (mem_ce && !mdl_busy && !hold_model) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= 2'd3;
    end
  end
  always @(negedge clk) begin
    if ((cpu_ack && vic_ack) || (p_cpu_ack && p_vic_ack)) both_ack++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic finish_txn(input string tag, input logic vic, input logic we,
                            input logic [15:0] addr, input logic [7:0] rv);
    int t = 0;
    while (!(cpu_ack || vic_ack) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ack"}, {cpu_ack, vic_ack}, {~vic, vic});
    check({tag, "_addr_held"}, mem_addr, addr);
    check({tag, "_err"}, err, 0);
    if (!we) check({tag, "_rdata"}, vic ? vic_rdata : cpu_rdata, rv);
    cpu_req = 1'b0;
    vic_req = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {cpu_ack, vic_ack, arb_busy}, 0);
    if (!we) check({tag, "_rhold"}, vic ? vic_rdata : cpu_rdata, rv);
  endtask
  task automatic txn(input string tag, input logic vic, input logic we, input logic [6:0] bank,
                     input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rv);
    rd_val = rv;
    if (vic) begin
      vic_req = 1'b1; vic_bank = bank; vic_addr = addr;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_bank = bank; cpu_addr = addr; cpu_wdata = wd;
    end
    @(negedge clk);
    check({tag, "_ce"}, mem_ce, 1);
    check({tag, "_mem"}, {mem_write, mem_bank, mem_addr}, {we, bank, addr});
    if (we) check({tag, "_wdata"}, mem_wdata, wd);
    cpu_bank = ~bank; cpu_addr = ~addr; cpu_wdata = ~wd; cpu_we = ~we;
    vic_bank = ~bank; vic_addr = ~addr;
    finish_txn(tag, vic, we, addr, rv);
  endtask
  initial begin
    logic [3:0] seq0 = '0, seq1 = '0;
    int t, seen, late;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 0);
    reset = 1'b1;
    rd_val = 8'hA5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 7'd3; cpu_addr = 16'h1234;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (mem_ce || arb_busy) seen++;
    end
    check("init_busy_no_grant", seen, 0);
    force_busy = 1'b0;
    @(negedge clk);
    check("init_ce", mem_ce, 1);
    check("init_mem", {mem_write, mem_bank, mem_addr}, {1'b0, 7'd3, 16'h1234});
    finish_txn("cpu_rd", 1'b0, 1'b0, 16'h1234, 8'hA5);
    txn("vic_rd", 1'b1, 1'b0, 7'd5, 16'h4000, 8'h00, 8'h3C);
    check("cpu_rdata_kept", cpu_rdata, 8'hA5);
    txn("cpu_wr", 1'b0, 1'b1, 7'd0, 16'hD020, 8'h5A, 8'h00);
    check("vic_rdata_kept", vic_rdata, 8'h3C);
    rd_val = 8'h77;
    cpu_we = 1'b0; cpu_bank = 7'd1; cpu_addr = 16'h0100; vic_bank = 7'd2; vic_addr = 16'h0200;
    cpu_req = 1'b1; vic_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      @(negedge clk);
      while (!(cpu_ack || vic_ack) && t < 50) begin
        @(negedge clk);
        t++;
      end
      seq0 = {seq0[2:0], vic_ack};
      seq1 = {seq1[2:0], p_vic_ack};
    end
    cpu_req = 1'b0; vic_req = 1'b0;
    check("rr_order", seq0, 4'b1010);
    check("vic_prio_order", seq1, 4'b1111);
    @(negedge clk);
    rd_val = 8'h99;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 7'd4; cpu_addr = 16'h4444;
    @(negedge clk);
    t = 0;
    while (!(arb_busy && !mem_ce) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reach_done", {arb_busy, mem_ce}, 2'b10);
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_mid_outs", outs, 0);
    reset = 1'b1;
    late = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack || vic_ack || arb_busy) late++;
    end
    check("rst_no_ack", late, 0);
    txn("post_rst_vic", 1'b1, 1'b0, 7'h7F, 16'hFFFF, 8'h00, 8'hC3);
`ifdef MEM_ARB_TIMEOUT_EN
    hold_model = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 7'd0; cpu_addr = 16'h0000;
    @(negedge clk);
    t = 0;
    while (!(cpu_ack || vic_ack) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("to_cycles", t, 16);
    check("to_ack_err", {cpu_ack, err, cpu_rdata}, {1'b1, 1'b1, 8'hFF});
    cpu_req = 1'b0;
    hold_model = 1'b0;
    @(negedge clk);
    check("to_idle", {arb_busy, err, mem_ce}, 0);
`endif
    check("ack_exclusive", both_ack, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
